// File: rtl/leaf_port_buffer_pkg.sv
// Shared helpers for the leaf port buffer: depth bound, saturating counter step,
// channel slice arithmetic and the per-cycle FIFO operation code.
package leaf_pkg;

  // Width of the scratch word the saturating increment works in.
  localparam int unsigned CNT_WORD_BITS = 32;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_BOTH
  } fifo_op_e;

  function automatic int unsigned depth_of(input int unsigned depth_bits);
    return 32'd1 << depth_bits;
  endfunction

  // Lowest bit of channel k inside a flat bus of w-bit slices.
  function automatic int unsigned chan_lsb(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

  function automatic logic [CNT_WORD_BITS-1:0] sat_inc(input logic [CNT_WORD_BITS-1:0] value,
                                                       input int unsigned width);
    logic [CNT_WORD_BITS-1:0] max_val;
    max_val = (width >= CNT_WORD_BITS) ? '1 : ((CNT_WORD_BITS'(1) << width) - CNT_WORD_BITS'(1));
    return (value >= max_val) ? max_val : value + CNT_WORD_BITS'(1);
  endfunction

endpackage

// File: rtl/leaf_port_buffer_if.sv
// One valid/ack word stream; master drives data and valid, slave drives ack.
interface leaf_port_buffer_if #(
  parameter int W = 32
) ();
  logic [W-1:0] data;
  logic         vld;
  logic         ack;

  modport master (output data, output vld, input ack);
  modport slave  (input data, input vld, output ack);
endinterface

// File: rtl/leaf_port_fifo.sv
// Single-channel FIFO between an upstream and a downstream vld/ack stream.
// The head word is presented combinationally so an entry is visible one cycle after its push.
module leaf_port_fifo
  import leaf_pkg::*;
#(
  parameter int PAYLOAD_BITS    = 32,
  parameter int FIFO_DEPTH_BITS = 2
) (
  input  logic              i_clk,
  input  logic              i_srst,
  input  logic              i_enable,
  input  logic              i_flush,
  leaf_port_buffer_if.slave  up,
  leaf_port_buffer_if.master dn,
  output logic              o_empty,
  output logic              o_pop
);

  localparam int unsigned DEPTH = depth_of(FIFO_DEPTH_BITS);
  localparam logic [FIFO_DEPTH_BITS:0] DEPTH_CNT = (FIFO_DEPTH_BITS+1)'(DEPTH);

  logic [PAYLOAD_BITS-1:0]    r_mem [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] r_wr_ptr;
  logic [FIFO_DEPTH_BITS-1:0] r_rd_ptr;
  logic [FIFO_DEPTH_BITS:0]   r_count;

  logic     w_ack;
  logic     w_vld;
  logic     w_push;
  logic     w_pop;
  fifo_op_e w_op;

  // Ack looks only at our own occupancy, so a full FIFO refuses even when a pop is under way.
  assign w_ack  = i_enable & ~i_flush & ~i_srst & (r_count != DEPTH_CNT);
  assign w_vld  = i_enable & ~i_flush & ~i_srst & (r_count != '0);
  assign w_push = up.vld & w_ack;
  assign w_pop  = w_vld & dn.ack;

  assign up.ack  = w_ack;
  assign dn.vld  = w_vld;
  assign dn.data = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_pop   = w_pop;

  always_comb begin
    w_op = OP_IDLE;
    case ({w_push, w_pop})
      2'b10:   w_op = OP_PUSH;
      2'b01:   w_op = OP_POP;
      2'b11:   w_op = OP_BOTH;
      default: w_op = OP_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= up.data;
    end
  end

  // Pointers are exactly FIFO_DEPTH_BITS wide, so they wrap modulo the depth for free.
  always_ff @(posedge i_clk) begin
    if (i_srst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      case (w_op)
        OP_PUSH: begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
          r_count  <= r_count + 1'b1;
        end
        OP_POP: begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
          r_count  <= r_count - 1'b1;
        end
        OP_BOTH: begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        default: begin
          r_count <= r_count;
        end
      endcase
    end
  end

endmodule

// File: rtl/leaf_port_buffer.sv
// Per-channel buffering between leaf_interface and the user operator, with a
// saturating delivered-word counter per channel and a global idle flag.
module leaf_port_buffer
  import leaf_pkg::*;
#(
  parameter int PAYLOAD_BITS    = 32,
  parameter int NUM_IN_PORTS    = 3,
  parameter int NUM_OUT_PORTS   = 1,
  parameter int FIFO_DEPTH_BITS = 2,
  parameter int CNT_BITS        = 16
) (
  input  logic                                        clk_user,
  input  logic                                        reset,
  input  logic                                        enable,
  input  logic                                        flush,
  input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]        in_data_up,
  input  logic [NUM_IN_PORTS-1:0]                     in_vld_up,
  output logic [NUM_IN_PORTS-1:0]                     in_ack_up,
  output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]        in_data_dn,
  output logic [NUM_IN_PORTS-1:0]                     in_vld_dn,
  input  logic [NUM_IN_PORTS-1:0]                     in_ack_dn,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]       out_data_up,
  input  logic [NUM_OUT_PORTS-1:0]                    out_vld_up,
  output logic [NUM_OUT_PORTS-1:0]                    out_ack_up,
  output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]       out_data_dn,
  output logic [NUM_OUT_PORTS-1:0]                    out_vld_dn,
  input  logic [NUM_OUT_PORTS-1:0]                    out_ack_dn,
  output logic                                        idle,
  output logic [(NUM_IN_PORTS+NUM_OUT_PORTS)*CNT_BITS-1:0] xfer_cnt
);

  localparam int NUM_CH = NUM_IN_PORTS + NUM_OUT_PORTS;

  logic [NUM_CH-1:0] w_empty;
  logic [NUM_CH-1:0] w_pop;

  genvar gi;

  generate
    for (gi = 0; gi < NUM_IN_PORTS; gi++) begin : g_in
      leaf_port_buffer_if #(.W(PAYLOAD_BITS)) u_up_if ();
      leaf_port_buffer_if #(.W(PAYLOAD_BITS)) u_dn_if ();

      assign u_up_if.data = in_data_up[chan_lsb(gi, PAYLOAD_BITS) +: PAYLOAD_BITS];
      assign u_up_if.vld  = in_vld_up[gi];
      assign in_ack_up[gi] = u_up_if.ack;
      assign in_data_dn[chan_lsb(gi, PAYLOAD_BITS) +: PAYLOAD_BITS] = u_dn_if.data;
      assign in_vld_dn[gi] = u_dn_if.vld;
      assign u_dn_if.ack  = in_ack_dn[gi];

      leaf_port_fifo #(
        .PAYLOAD_BITS    (PAYLOAD_BITS),
        .FIFO_DEPTH_BITS (FIFO_DEPTH_BITS)
      ) u_fifo (
        .i_clk    (clk_user),
        .i_srst   (reset),
        .i_enable (enable),
        .i_flush  (flush),
        .up       (u_up_if.slave),
        .dn       (u_dn_if.master),
        .o_empty  (w_empty[gi]),
        .o_pop    (w_pop[gi])
      );
    end

    for (gi = 0; gi < NUM_OUT_PORTS; gi++) begin : g_out
      leaf_port_buffer_if #(.W(PAYLOAD_BITS)) u_up_if ();
      leaf_port_buffer_if #(.W(PAYLOAD_BITS)) u_dn_if ();

      assign u_up_if.data = out_data_up[chan_lsb(gi, PAYLOAD_BITS) +: PAYLOAD_BITS];
      assign u_up_if.vld  = out_vld_up[gi];
      assign out_ack_up[gi] = u_up_if.ack;
      assign out_data_dn[chan_lsb(gi, PAYLOAD_BITS) +: PAYLOAD_BITS] = u_dn_if.data;
      assign out_vld_dn[gi] = u_dn_if.vld;
      assign u_dn_if.ack  = out_ack_dn[gi];

      leaf_port_fifo #(
        .PAYLOAD_BITS    (PAYLOAD_BITS),
        .FIFO_DEPTH_BITS (FIFO_DEPTH_BITS)
      ) u_fifo (
        .i_clk    (clk_user),
        .i_srst   (reset),
        .i_enable (enable),
        .i_flush  (flush),
        .up       (u_up_if.slave),
        .dn       (u_dn_if.master),
        .o_empty  (w_empty[NUM_IN_PORTS+gi]),
        .o_pop    (w_pop[NUM_IN_PORTS+gi])
      );
    end

    // Counters survive flush and enable-low; only reset clears them.
    for (gi = 0; gi < NUM_CH; gi++) begin : g_cnt
      logic [CNT_BITS-1:0] r_xfer_cnt;

      always_ff @(posedge clk_user) begin
        if (reset) begin
          r_xfer_cnt <= '0;
        end else if (w_pop[gi]) begin
          r_xfer_cnt <= CNT_BITS'(sat_inc(CNT_WORD_BITS'(r_xfer_cnt), CNT_BITS));
        end
      end

      assign xfer_cnt[chan_lsb(gi, CNT_BITS) +: CNT_BITS] = r_xfer_cnt;
    end
  endgenerate

  assign idle = &w_empty;

endmodule

// File: tb/tb_leaf_port_buffer.sv
// Directed bench for leaf_port_buffer: queue-based reference model checked every
// cycle on the falling edge, plus literal expectations for each scenario.
module tb_leaf_port_buffer;

  localparam int PB  = 32;
  localparam int NI  = 3;
  localparam int NO  = 1;
  localparam int DB  = 2;
  localparam int CB  = 4;
  localparam int NCH = NI + NO;
  localparam int DEPTH = 4;
  localparam int CMAX  = 15;

  logic              clk_user = 1'b0;
  logic              reset;
  logic              enable;
  logic              flush;
  logic [NI*PB-1:0]  in_data_up;
  logic [NI-1:0]     in_vld_up;
  logic [NI-1:0]     in_ack_up;
  logic [NI*PB-1:0]  in_data_dn;
  logic [NI-1:0]     in_vld_dn;
  logic [NI-1:0]     in_ack_dn;
  logic [NO*PB-1:0]  out_data_up;
  logic [NO-1:0]     out_vld_up;
  logic [NO-1:0]     out_ack_up;
  logic [NO*PB-1:0]  out_data_dn;
  logic [NO-1:0]     out_vld_dn;
  logic [NO-1:0]     out_ack_dn;
  logic              idle;
  logic [NCH*CB-1:0] xfer_cnt;

  always #5 clk_user = ~clk_user;

  leaf_port_buffer #(
    .PAYLOAD_BITS    (PB),
    .NUM_IN_PORTS    (NI),
    .NUM_OUT_PORTS   (NO),
    .FIFO_DEPTH_BITS (DB),
    .CNT_BITS        (CB)
  ) dut (
    .clk_user    (clk_user),
    .reset       (reset),
    .enable      (enable),
    .flush       (flush),
    .in_data_up  (in_data_up),
    .in_vld_up   (in_vld_up),
    .in_ack_up   (in_ack_up),
    .in_data_dn  (in_data_dn),
    .in_vld_dn   (in_vld_dn),
    .in_ack_dn   (in_ack_dn),
    .out_data_up (out_data_up),
    .out_vld_up  (out_vld_up),
    .out_ack_up  (out_ack_up),
    .out_data_dn (out_data_dn),
    .out_vld_dn  (out_vld_dn),
    .out_ack_dn  (out_ack_dn),
    .idle        (idle),
    .xfer_cnt    (xfer_cnt)
  );

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  // Reference model: one queue of words and one delivered count per channel.
  logic [31:0] mq [NCH][$];
  int          mcnt [NCH];

  logic [31:0] got0 [$];
  int          acc0 = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic up_vld(input int k);
    if (k < NI) return in_vld_up[k];
    return out_vld_up[0];
  endfunction

  function automatic logic [31:0] up_data(input int k);
    if (k < NI) return in_data_up[k*PB +: PB];
    return out_data_up[PB-1:0];
  endfunction

  function automatic logic dn_ack(input int k);
    if (k < NI) return in_ack_dn[k];
    return out_ack_dn[0];
  endfunction

  function automatic logic dut_ack_up(input int k);
    if (k < NI) return in_ack_up[k];
    return out_ack_up[0];
  endfunction

  function automatic logic dut_vld_dn(input int k);
    if (k < NI) return in_vld_dn[k];
    return out_vld_dn[0];
  endfunction

  function automatic logic [31:0] dut_data_dn(input int k);
    if (k < NI) return in_data_dn[k*PB +: PB];
    return out_data_dn[PB-1:0];
  endfunction

  logic ea, ev, all_empty, do_pop, do_push;

  // Compare on the falling edge, then advance the model to the state the next rising edge produces.
  always @(negedge clk_user) begin
    if (chk_en) begin
      all_empty = 1'b1;
      for (int k = 0; k < NCH; k++) begin
        ea = enable & ~flush & ~reset & (mq[k].size() < DEPTH);
        ev = enable & ~flush & ~reset & (mq[k].size() > 0);
        if (mq[k].size() > 0) all_empty = 1'b0;
        check($sformatf("ack_up ch%0d", k), 32'(dut_ack_up(k)), 32'(ea));
        check($sformatf("vld_dn ch%0d", k), 32'(dut_vld_dn(k)), 32'(ev));
        if (ev) check($sformatf("data_dn ch%0d", k), dut_data_dn(k), mq[k][0]);
        check($sformatf("xfer_cnt ch%0d", k), 32'(xfer_cnt[k*CB +: CB]), 32'(mcnt[k]));
      end
      check("idle", 32'(idle), 32'(all_empty));
    end

    if (in_vld_dn[0] && in_ack_dn[0]) begin
      got0.push_back(in_data_dn[PB-1:0]);
      $display("xfer ch0 data=%h", in_data_dn[PB-1:0]);
    end
    if (in_vld_up[0] && in_ack_up[0]) acc0++;

    if (reset) begin
      for (int k = 0; k < NCH; k++) begin
        mq[k].delete();
        mcnt[k] = 0;
      end
    end else if (flush) begin
      for (int k = 0; k < NCH; k++) mq[k].delete();
    end else if (enable) begin
      for (int k = 0; k < NCH; k++) begin
        do_pop  = (mq[k].size() > 0) && dn_ack(k);
        do_push = (mq[k].size() < DEPTH) && up_vld(k);
        if (do_pop) begin
          void'(mq[k].pop_front());
          if (mcnt[k] < CMAX) mcnt[k]++;
        end
        if (do_push) mq[k].push_back(up_data(k));
      end
    end
  end

  task automatic tick;
    @(posedge clk_user);
    #1;
  endtask

  task automatic clear_inputs;
    flush       = 1'b0;
    in_data_up  = '0;
    in_vld_up   = '0;
    in_ack_dn   = '0;
    out_data_up = '0;
    out_vld_up  = '0;
    out_ack_dn  = '0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    clear_inputs();
    tick();
    check("reset idle", 32'(idle), 32'd1);
    check("reset xfer_cnt", 32'(xfer_cnt), 32'd0);
    tick();
    reset  = 1'b0;
    enable = 1'b1;
    got0.delete();
    acc0 = 0;
  endtask

  logic [31:0] exp_words [$];

  task automatic check_got0(input string name);
    check({name, " count"}, 32'(got0.size()), 32'(exp_words.size()));
    for (int i = 0; i < exp_words.size() && i < got0.size(); i++)
      check($sformatf("%s word%0d", name, i), got0[i], exp_words[i]);
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    clear_inputs();
    for (int k = 0; k < NCH; k++) mcnt[k] = 0;
    @(posedge clk_user);
    #1;
    chk_en = 1'b1;

    // Pass-through on channel 0
    do_reset();
    in_ack_dn = 3'b111;
    in_data_up[31:0] = 32'h11; in_vld_up[0] = 1'b1;
    tick();
    check("pass vld at cycle1", 32'(in_vld_dn[0]), 32'd1);
    check("pass head at cycle1", in_data_dn[31:0], 32'h11);
    in_data_up[31:0] = 32'h22;
    tick();
    in_data_up[31:0] = 32'h33;
    tick();
    in_vld_up = '0;
    repeat (3) tick();
    exp_words = '{32'h11, 32'h22, 32'h33};
    check_got0("pass");
    check("pass cnt ch0", 32'(xfer_cnt[CB-1:0]), 32'd3);

    // Fill to depth, then drain
    do_reset();
    in_ack_dn = '0;
    for (int i = 0; i < 5; i++) begin
      in_data_up[31:0] = 32'hA0 + 32'(i);
      in_vld_up[0] = 1'b1;
      tick();
    end
    check("full accepted", 32'(acc0), 32'd4);
    check("full ack low", 32'(in_ack_up[0]), 32'd0);
    in_vld_up = '0;
    in_ack_dn[0] = 1'b1;
    tick();
    check("full ack after pop", 32'(in_ack_up[0]), 32'd1);
    repeat (4) tick();
    exp_words = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    check_got0("full");

    // Wrap-around with downstream ack toggling
    do_reset();
    for (int cyc = 0; cyc < 200 && got0.size() < 10; cyc++) begin
      in_vld_up[0] = (acc0 < 10);
      in_data_up[31:0] = 32'h100 + 32'(acc0);
      in_ack_dn[0] = (cyc % 2 == 0);
      tick();
    end
    in_vld_up = '0;
    in_ack_dn = '0;
    tick();
    exp_words.delete();
    for (int i = 0; i < 10; i++) exp_words.push_back(32'h100 + 32'(i));
    check_got0("wrap");
    check("wrap idle", 32'(idle), 32'd1);

    // Flush, then enable low
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_data_up[31:0] = 32'hB0 + 32'(i);
      in_vld_up[0] = 1'b1;
      tick();
    end
    in_vld_up = '0;
    in_ack_dn[0] = 1'b1;
    tick();
    in_ack_dn = '0;
    check("pre-flush idle", 32'(idle), 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush idle", 32'(idle), 32'd1);
    check("flush cnt ch0", 32'(xfer_cnt[CB-1:0]), 32'd1);
    got0.delete();
    in_vld_up[0] = 1'b1;
    in_data_up[31:0] = 32'h55;
    tick();
    in_data_up[31:0] = 32'h66;
    tick();
    enable = 1'b0;
    in_data_up[31:0] = 32'h77;
    in_ack_dn[0] = 1'b1;
    repeat (3) begin
      tick();
      check("dis vld", 32'(in_vld_dn), 32'd0);
      check("dis ack", 32'(in_ack_up), 32'd0);
    end
    check("dis idle", 32'(idle), 32'd0);
    check("dis cnt ch0", 32'(xfer_cnt[CB-1:0]), 32'd1);
    in_vld_up = '0;
    enable = 1'b1;
    repeat (3) tick();
    exp_words = '{32'h55, 32'h66};
    check_got0("enable");
    check("enable cnt ch0", 32'(xfer_cnt[CB-1:0]), 32'd3);

    // Saturation on every channel, then reset mid-stream
    do_reset();
    in_ack_dn  = 3'b111;
    out_ack_dn = 1'b1;
    for (int i = 0; i < 22; i++) begin
      in_vld_up  = 3'b111;
      out_vld_up = 1'b1;
      in_data_up = {32'h300 + 32'(i), 32'h200 + 32'(i), 32'h100 + 32'(i)};
      out_data_up = 32'h400 + 32'(i);
      tick();
    end
    in_vld_up  = '0;
    out_vld_up = '0;
    repeat (3) tick();
    check("sat cnt ch0", 32'(xfer_cnt[CB-1:0]), 32'd15);
    check("sat cnt ch3", 32'(xfer_cnt[4*CB-1:3*CB]), 32'd15);
    in_ack_dn = '0;
    in_vld_up = 3'b111;
    in_data_up = {32'hC3, 32'hC2, 32'hC1};
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check("rst vld", 32'(in_vld_dn), 32'd0);
    check("rst ack", 32'(in_ack_up), 32'd0);
    reset = 1'b0;
    in_vld_up = '0;
    got0.delete();
    check("rst idle", 32'(idle), 32'd1);
    check("rst xfer_cnt", 32'(xfer_cnt), 32'd0);
    in_ack_dn = 3'b111;
    repeat (3) tick();
    check("no stale word", 32'(got0.size()), 32'd0);
    check("rst end idle", 32'(idle), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
